// File: rtl/hdc_pkg.sv
// hdc_pkg: shared types and helpers for the HDC clean-up memory.
// Bipolar encoding: bit 0 means +1, bit 1 means -1.
package hdc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } mcu_state_t;

    localparam logic BIP_POS = 1'b0;
    localparam logic BIP_NEG = 1'b1;

    // Accumulator width that holds len terms of bits-wide signed
    // coefficients, including the negated most-negative value.
    function automatic int sum_width(input int len, input int bits);
        return bits + $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/mem_clean_up_row_dot.sv
// mem_clean_up_row_dot: one row of sign(XXT * x_hat), combinational.
// A zero dot product keeps the previous estimate bit for that row.
module mem_clean_up_row_dot
    import hdc_pkg::*;
#(
    parameter int VECTOR_LEN        = 64,
    parameter int NUM_CODEBOOK_BITS = 4
) (
    input  logic [VECTOR_LEN-1:0][NUM_CODEBOOK_BITS-1:0] row_i,
    input  logic [VECTOR_LEN-1:0]                        x_i,
    input  logic                                         prev_i,
    output logic                                         bit_o
);

    localparam int SUM_W = sum_width(VECTOR_LEN, NUM_CODEBOOK_BITS);
    localparam int EXT_W = SUM_W - NUM_CODEBOOK_BITS;

    logic signed [SUM_W-1:0] sum;

    // Signed accumulation of the row against the bipolar estimate;
    // negation happens after widening so -2^(N-1) cannot overflow.
    always_comb begin
        logic signed [SUM_W-1:0] term;
        term = '0;
        sum  = '0;
        for (int j = 0; j < VECTOR_LEN; j++) begin
            term = {{EXT_W{row_i[j][NUM_CODEBOOK_BITS-1]}}, row_i[j]};
            if (x_i[j] == BIP_NEG) begin
                term = -term;
            end
            sum = sum + term;
        end
    end

    // Sign threshold with tie-to-previous.
    always_comb begin
        if (sum[SUM_W-1]) begin
            bit_o = BIP_NEG;
        end else if (sum != '0) begin
            bit_o = BIP_POS;
        end else begin
            bit_o = prev_i;
        end
    end

endmodule

// File: rtl/mem_clean_up_seq.sv
// mem_clean_up_seq: sequential clean-up memory, LANES rows of XXT per cycle.
// Optional macro MEM_CLEAN_UP_SEQ_CONVERGE_EN adds the converged output.
module mem_clean_up_seq
    import hdc_pkg::*;
#(
    parameter int VECTOR_LEN        = 64,
    parameter int NUM_CODEBOOK_BITS = 4,
    parameter int LANES             = 4,
    parameter logic signed [VECTOR_LEN-1:0][VECTOR_LEN-1:0][NUM_CODEBOOK_BITS-1:0]
        XXT = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [VECTOR_LEN-1:0] x_hat_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [VECTOR_LEN-1:0] x_hat_out
`ifdef MEM_CLEAN_UP_SEQ_CONVERGE_EN
    ,
    output logic                  converged
`endif
);

    localparam int IDX_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
    localparam logic [IDX_W-1:0] STEP     = IDX_W'(LANES);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(VECTOR_LEN - LANES);

    mcu_state_t state_q, state_d;

    logic [IDX_W-1:0]      row_idx_q, row_idx_d;
    logic                  last_q, last_d;
    logic [VECTOR_LEN-1:0] x_q, x_d;
    logic [VECTOR_LEN-1:0] res_q, res_d;
    logic [VECTOR_LEN-1:0] out_q, out_d;
    logic                  out_valid_q, out_valid_d;
`ifdef MEM_CLEAN_UP_SEQ_CONVERGE_EN
    logic                  conv_q, conv_d;
`endif

    logic [LANES-1:0][IDX_W-1:0] row_sel;
    logic [LANES-1:0]            lane_bit;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign row_sel[l] = row_idx_q + IDX_W'(l);

        mem_clean_up_row_dot #(
            .VECTOR_LEN       (VECTOR_LEN),
            .NUM_CODEBOOK_BITS(NUM_CODEBOOK_BITS)
        ) u_dot (
            .row_i (XXT[row_sel[l]]),
            .x_i   (x_q),
            .prev_i(x_q[row_sel[l]]),
            .bit_o (lane_bit[l])
        );
    end

    // FSM and datapath next state: capture, LANES-row passes, publish, hold.
    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        last_d      = last_q;
        x_d         = x_q;
        res_d       = res_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
`ifdef MEM_CLEAN_UP_SEQ_CONVERGE_EN
        conv_d      = conv_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d       = x_hat_in;
                    row_idx_d = '0;
                    last_d    = 1'b0;
                    state_d   = COMPUTE;
                end
            end
            COMPUTE: begin
                if (!last_q) begin
                    for (int l = 0; l < LANES; l++) begin
                        res_d[row_sel[l]] = lane_bit[l];
                    end
                    row_idx_d = row_idx_q + STEP;
                    if (row_idx_q == LAST_ROW) begin
                        last_d = 1'b1;
                    end
                end else begin
                    out_d       = res_q;
                    out_valid_d = 1'b1;
`ifdef MEM_CLEAN_UP_SEQ_CONVERGE_EN
                    conv_d      = (res_q == x_q);
`endif
                    last_d      = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_idx_q   <= '0;
            last_q      <= 1'b0;
            x_q         <= '0;
            res_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef MEM_CLEAN_UP_SEQ_CONVERGE_EN
            conv_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            last_q      <= last_d;
            x_q         <= x_d;
            res_q       <= res_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef MEM_CLEAN_UP_SEQ_CONVERGE_EN
            conv_q      <= conv_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign x_hat_out = out_q;
`ifdef MEM_CLEAN_UP_SEQ_CONVERGE_EN
    assign converged = conv_q;
`endif

endmodule
